// File: rtl/counter.sv
// Free-running binary up-counter with asynchronous active-low reset.
// The count wraps modulo 2^WIDTH and is driven straight from the state
// register, so there is no combinational path from any input to out.
module counter #(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] out
);

    // Increment constant sized to the counter so the sum truncates cleanly
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    // Count state: cleared the moment reset drops, otherwise +1 per rising edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= RESET_VALUE;
        end else begin
            r_count <= r_count + ONE;
        end
    end

    assign out = r_count;

endmodule

// File: tb/tb_counter.sv
// Directed testbench for counter: a reference model pushes the expected
// count into a scoreboard queue as each step is driven, and the value is
// popped and compared against the DUT shortly after the clock edge.
module tb_counter;

    localparam int WIDTH = 4;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] out;

    logic [WIDTH-1:0] model;
    logic [WIDTH-1:0] expQ[$];
    int               checks;
    int               failures;

    counter #(
        .WIDTH      (WIDTH),
        .RESET_VALUE('0)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .out  (out)
    );

    // 10-unit clock with the first rising edge at t=5
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against the run never reaching its summary line
    initial begin
        #5000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Record the value the model says out must hold at the next sample point
    task automatic applyStimulus();
        expQ.push_back(model);
    endtask

    // Pop the oldest expectation and compare it with the DUT output
    task automatic checkOutput(input string tag);
        logic [WIDTH-1:0] exp;
        checks++;
        if (expQ.size() == 0) begin
            failures++;
            $display("[TB] FAIL %s observed=%0d expected=<empty scoreboard>", tag, out);
        end else begin
            exp = expQ.pop_front();
            assert (out === exp) else begin
                failures++;
                $error("[TB] FAIL %s observed=%0d expected=%0d", tag, out, exp);
            end
        end
    endtask

    // One clock edge: advance the model if out of reset, then sample at +1
    task automatic clockStep(input string tag);
        @(posedge clk);
        if (reset) model = model + WIDTH'(1);
        applyStimulus();
        #1;
        checkOutput(tag);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        model    = '0;
        reset    = 1'b0;

        // Reset held low from t=0: out is 0 and ignores the edges at 5 and 15
        #1;
        applyStimulus();
        checkOutput("reset_t1");
        clockStep("reset_edge5");
        clockStep("reset_edge15");

        // Release at t=20, away from any edge; no change until the next edge
        #4;
        reset = 1'b1;
        #1;
        applyStimulus();
        checkOutput("release_t21");

        // Edges 25..95 give 1..8
        for (int i = 0; i < 8; i++) clockStep($sformatf("count_%0d", i + 1));

        // Assert reset at t=100 between edges: out must clear without a clock
        #4;
        reset = 1'b0;
        model = '0;
        #1;
        applyStimulus();
        checkOutput("async_clear_t101");
        for (int i = 0; i < 5; i++) clockStep($sformatf("held_reset_%0d", i));

        // Release at t=150: out 1 after 155, 2 after 165
        #4;
        reset = 1'b1;
        clockStep("restart_1");
        clockStep("restart_2");

        // Clear again mid-count, then run 17 edges to cover the wrap 15 -> 0 -> 1
        #2;
        reset = 1'b0;
        model = '0;
        #1;
        applyStimulus();
        checkOutput("midcount_clear");
        #1;
        reset = 1'b1;
        for (int i = 0; i < 17; i++) clockStep($sformatf("wrap_%0d", i + 1));

        // Final explicit boundary check: after 17 edges from 0 the count is 1
        expQ.push_back(WIDTH'(1));
        checkOutput("wrap_final_is_1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
